// File: rtl/skip_subtractor8_pipe.sv
// Pipelined carry-skip subtractor: diff = a - b - bi, one BLOCK-bit skip group per stage.
// Define SKIP_SUB_SAT_EN to clamp diff to 0 whenever a borrow-out occurs.
module skip_subtractor8_pipe #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ov
);

    localparam int STAGES = WIDTH / BLOCK;

    typedef struct packed {
        logic             vld;
        logic             cry;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opnb;
        logic [WIDTH-1:0] res;
    } beat_t;

    beat_t             src [STAGES];
    beat_t             nxt [STAGES];
    beat_t             r   [STAGES-1];
    logic [STAGES-1:0] adv;
    logic              last_bo;
    logic              last_ov;

    // Resolve group k: ripple sum bits, carry bypasses the group when it fully propagates.
    function automatic beat_t group_step(input beat_t s, input int k);
        logic [BLOCK-1:0] ag;
        logic [BLOCK-1:0] bg;
        logic [BLOCK-1:0] sg;
        logic             c;
        logic             p;
        beat_t            o;
        ag = s.opa[k*BLOCK +: BLOCK];
        bg = s.opnb[k*BLOCK +: BLOCK];
        c  = s.cry;
        for (int i = 0; i < BLOCK; i++) begin
            sg[i] = ag[i] ^ bg[i] ^ c;
            c     = (ag[i] & bg[i]) | (c & (ag[i] ^ bg[i]));
        end
        p = &(ag ^ bg);
        o = s;
        o.res[k*BLOCK +: BLOCK] = sg;
        o.cry = p ? s.cry : c;
        return o;
    endfunction

    always_comb begin
        adv[STAGES-1] = ~out_valid | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~r[k].vld | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        src[0] = '{vld: in_valid, cry: ~bi, opa: a, opnb: ~b, res: '0};
        for (int k = 1; k < STAGES; k++) begin
            src[k] = r[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            nxt[k] = group_step(src[k], k);
        end
    end

    always_comb begin
        last_bo = ~nxt[STAGES-1].cry;
        last_ov = (nxt[STAGES-1].opa[WIDTH-1] ^ ~nxt[STAGES-1].opnb[WIDTH-1])
                & (nxt[STAGES-1].opa[WIDTH-1] ^ nxt[STAGES-1].res[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES - 1; k++) begin
                if (adv[k]) begin
                    if (src[k].vld) begin
                        r[k] <= nxt[k];
                    end else begin
                        r[k].vld <= 1'b0;
                    end
                end
            end
        end
    end

    // Result registers only change when a real beat lands in the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bo        <= 1'b0;
            ov        <= 1'b0;
        end else if (adv[STAGES-1]) begin
            out_valid <= src[STAGES-1].vld;
            if (src[STAGES-1].vld) begin
`ifdef SKIP_SUB_SAT_EN
                diff <= last_bo ? '0 : nxt[STAGES-1].res;
`else
                diff <= nxt[STAGES-1].res;
`endif
                bo   <= last_bo;
                ov   <= last_ov;
            end
        end
    end

endmodule

// File: tb/tb_skip_subtractor8_pipe.sv
// Scoreboard bench for skip_subtractor8_pipe: directed vectors, backpressure, reset.
module tb_skip_subtractor8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       bo;
    logic       ov;

`ifdef SKIP_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         t;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          timed = 1'b0;
    logic [10:0] hold_val;
    bit          hold_pend;

    skip_subtractor8_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bi(bi),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bo(bo), .ov(ov)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                        input logic [7:0] dv, input logic bov, input logic ovv,
                        input bit push);
        exp_t e;
        int   n;
        n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        bi = biv;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                if (push) begin
                    e.d  = (SAT && bov) ? 8'd0 : dv;
                    e.bo = bov;
                    e.ov = ovv;
                    e.t  = timed ? cyc + 2 : -1;
                    sb.push_back(e);
                end
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at %0b expected 1", in_ready);
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        bi = 1'b0;
        out_ready = 1'b1;
        hold_pend = 1'b0;
        hold_val = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst) begin
                    hold_pend = 1'b0;
                end else begin
                    if (hold_pend) begin
                        checks++;
                        if ({out_valid, diff, bo, ov} !== hold_val) begin
                            errors++;
                            $display("FAIL stall_hold: got %h expected %h",
                                     {out_valid, diff, bo, ov}, hold_val);
                        end
                    end
                    hold_pend = out_valid & ~out_ready;
                    hold_val  = {out_valid, diff, bo, ov};
                    if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_out: got diff=%0d with no beat expected", diff);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            if ({diff, bo, ov} !== {e.d, e.bo, e.ov}) begin
                                errors++;
                                $display("FAIL result: got diff=%0d bo=%0b ov=%0b expected diff=%0d bo=%0b ov=%0b",
                                         diff, bo, ov, e.d, e.bo, e.ov);
                            end
                            if (e.t >= 0) begin
                                checks++;
                                if (cyc != e.t) begin
                                    errors++;
                                    $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, e.t);
                                end
                            end
                        end
                    end
                end
            end
        join_none

        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bo", bo, 0);
        chk("rst_ov", ov, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Back-to-back with out_ready high: 2-cycle latency, one result per cycle.
        timed = 1'b1;
        send(8'd200, 8'd55,  1'b0, 8'd145, 1'b0, 1'b0, 1'b1);
        send(8'd5,   8'd10,  1'b1, 8'd250, 1'b1, 1'b0, 1'b1);
        send(8'd127, 8'd255, 1'b0, 8'd128, 1'b1, 1'b1, 1'b1);
        send(8'd128, 8'd1,   1'b0, 8'd127, 1'b0, 1'b1, 1'b1);
        send(8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 1'b0, 1'b1);
        send(8'd170, 8'd170, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1);
        timed = 1'b0;
        drain();

        // Backpressure: consumer stalls for cycles 3..7 of the burst.
        t0 = cyc;
        fork
            begin
                send(8'd100, 8'd30,  1'b0, 8'd70,  1'b0, 1'b0, 1'b1);
                send(8'd30,  8'd100, 1'b0, 8'd186, 1'b1, 1'b0, 1'b1);
                send(8'd255, 8'd1,   1'b1, 8'd253, 1'b0, 1'b0, 1'b1);
                send(8'd16,  8'd15,  1'b0, 8'd1,   1'b0, 1'b0, 1'b1);
                send(8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0, 1'b1);
                send(8'd129, 8'd2,   1'b0, 8'd127, 1'b0, 1'b1, 1'b1);
            end
            begin
                wait_cyc(t0 + 3);
                out_ready = 1'b0;
                wait_cyc(t0 + 7);
                @(negedge clk);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                wait_cyc(t0 + 8);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight, then a fresh beat.
        send(8'd11, 8'd1, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
        send(8'd22, 8'd2, 1'b0, 8'd20, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_bo", bo, 0);
        chk("midrst_ov", ov, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        timed = 1'b1;
        send(8'd37, 8'd48, 1'b0, 8'd245, 1'b1, 1'b0, 1'b1);
        timed = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/skip_subtractor8_pipe.md
Name: skip_subtractor8_pipe

Overview:
- Pipelined carry-skip subtractor. Computes diff = a - b - bi as a + ~b + ~bi through BLOCK-bit carry-skip groups.
- One skip group is evaluated per pipeline stage, and the carry is registered between stages.
- Provides the inverse operation to the existing 8-bit carry-skip adder in the arithmetic datapath.
- Uses valid/ready handshakes on both sides so it can sit between producer and consumer FIFOs.

Parameters:
- WIDTH, 8, operand width; must be a multiple of BLOCK.
- BLOCK, 4, skip-group width, which is also the bits resolved per stage.
- STAGES, WIDTH/BLOCK, derived localparam (not overridable); equals the pipeline depth.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage 0 can accept a beat.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bi  input  1  borrow-in (1 = subtract an extra 1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b - bi, modulo 2^WIDTH.
- bo  output  1  borrow-out (1 when a < b + bi, unsigned).
- ov  output  1  signed two's-complement overflow.

Behaviour:
- Reset (asynchronous, active-high, at any time including mid-operation):
  - All stage valid bits are cleared.
  - diff, bo, ov and out_valid go to 0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - In-flight beats are discarded.
- Stage k, for k = 0..STAGES-1:
  - Holds valid_k, the partial diff bits already resolved, the remaining a/~b slices, the carry c_k, and the operand MSBs needed for ov.
  - Computes group k: P = &(a_g ^ ~b_g); c_out = P ? c_in : ripple carry of the group.
  - Stage 0 uses c_in = ~bi.
- Advance rule:
  - adv_last = ~valid_last | out_ready.
  - adv_k = ~valid_k | adv_{k+1}.
  - in_ready = adv_0.
  - Bubbles collapse; a stage only holds when it is full and downstream is blocked.
- Transfer:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Latency and throughput:
  - Latency is exactly STAGES cycles from the input transfer to out_valid (2 cycles at default).
  - Throughput is 1 beat/cycle when out_ready is held at 1.
- Arithmetic:
  - diff = (a + ~b + ~bi) mod 2^WIDTH.
  - bo = ~carry_out of the final group.
  - ov = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]).
- Stalls:
  - While out_valid & ~out_ready, the outputs diff/bo/ov/out_valid hold stable.
  - Upstream stages fill, then in_ready drops to 0.
- Output registers are written only when a beat moves into the last stage; no combinational path from a/b to diff.
- Simultaneous output transfer and a new beat arriving at the last stage in the same cycle: the new beat replaces the old with no gap.
- in_valid is ignored while in_ready = 0; the producer must hold the operands.

Optional Feature:
- Macro: SKIP_SUB_SAT_EN.
- When defined, the block performs unsigned saturating subtraction:
  - If the computed bo = 1, diff is forced to 0.
  - bo still reports 1, so the consumer can detect clamping.
  - ov is unchanged (raw, unsaturated).
- When undefined, diff wraps modulo 2^WIDTH and no saturation logic is synthesised.
- Latency is identical in both builds.

Test Plan:
- Basic subtract: a=200, b=55, bi=0, out_ready=1 -> after 2 cycles diff=145, bo=0, ov=0.
- Borrow-in and wrap: a=5, b=10, bi=1 -> diff=250, bo=1, ov=0. With SKIP_SUB_SAT_EN: diff=0, bo=1.
- Signed overflow: a=127, b=255, bi=0 -> diff=128, bo=1, ov=1. Then a=128, b=1 -> diff=127, bo=0, ov=1.
- Full skip path: a=0, b=0, bi=1 (every group propagates) -> diff=255, bo=1, ov=0. Also a=170, b=170, bi=0 -> diff=0, bo=0.
- Backpressure and throughput:
  - Issue 6 back-to-back beats, with out_ready=0 from cycle 3 to cycle 7.
  - in_ready must fall once both stages are full.
  - Outputs hold stable during the stall.
  - All 6 results emerge in order with none lost or duplicated.
  - With out_ready=1 throughout, 1 result per cycle.
- Reset mid-operation:
  - Assert rst asynchronously (between clock edges) with 2 beats in flight.
  - out_valid=0 and diff=bo=ov=0 immediately.
  - After release, in_ready=1; the next beat a=37, b=48, bi=0 yields diff=245, bo=1 after 2 cycles.
